traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Parametrised multi-approach traffic-light controller: sequences NUM_DIR approaches round-robin through green → yellow → all-red phases with runtime-programmable durations, optional skipping of approaches with no demand, latched pedestrian walk requests and a flashing-yellow fault mode. It is a timed Moore FSM driven by an external timebase strobe and sits between the intersection I/O block (detectors, push-buttons) and the lamp drivers.

## Interface
- NUM_DIR, 2: number of approaches (2..8).
- CNT_W, 8: width of duration inputs and phase timer.
- WALK_TICKS, 4: ticks walk is held at start of a served green (≥1, ≤ green duration is the operator's responsibility; walk ends with green regardless).
- SKIP_EMPTY, 1: 1 = skip approaches without demand; 0 = pure round-robin.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick_en  in  1  one-cycle timebase strobe; all timing counts these.
- green_len  in  CNT_W  green duration in ticks, sampled at phase entry.
- yellow_len  in  CNT_W  yellow duration in ticks, sampled at phase entry.
- allred_len  in  CNT_W  all-red duration in ticks, sampled at phase entry.
- car_present  in  NUM_DIR  level detector per approach.
- ped_req  in  NUM_DIR  pedestrian push-button, one-cycle or level.
- flash_mode  in  1  request flashing-yellow mode.
- red / yellow / green  out  NUM_DIR each  lamp drives, registered.
- walk  out  NUM_DIR  walk signal, registered.
- active_dir  out  $clog2(NUM_DIR)  approach currently owning the phase.
- phase  out  2  encoded state (ALLRED=0, GREEN=1, YELLOW=2, FLASH=3).

## Operation
- States: ALLRED, GREEN, YELLOW, FLASH. Transitions: ALLRED→GREEN (on next_dir), GREEN→YELLOW, YELLOW→ALLRED; any→FLASH when flash_mode=1; FLASH→ALLRED with active_dir=0 when flash_mode=0 at a tick_en.
- Phase timer: on phase entry loads max(len,1)−1; decrements on tick_en; phase ends on tick_en with timer==0. Phase therefore lasts exactly max(len,1) ticks; len=0 behaves as 1.
- Next direction chosen at ALLRED exit: SKIP_EMPTY=1 → first index after active_dir (wrapping) with car_present or latched ped request; if none has demand, plain next index. SKIP_EMPTY=0 → plain next index (wrap NUM_DIR−1→0).
- Ped latch per approach: set by ped_req=1, persists until that approach enters GREEN; cleared on that entry, which asserts walk for that approach for WALK_TICKS ticks or until green ends, whichever first. Request arriving during own green is latched for the next service.
- Lamps: GREEN → green[active_dir]=1, red elsewhere. YELLOW → yellow[active_dir]=1, red elsewhere. ALLRED → all red. FLASH → red=green=walk=0, yellow all = blink bit, blink toggles on each tick_en, starts at 1 on FLASH entry.
- Exactly one lamp per approach lit except in FLASH; no two approaches green simultaneously, ever.
- Reset values: phase=ALLRED, active_dir=0, red all 1, yellow/green/walk all 0, ped latches 0, timer = 0 (first ALLRED lasts one tick).

## Timing
- All outputs change on the clk edge after the qualifying tick_en (1-cycle latency).
- flash_mode=1 enters FLASH on the next clk edge, independent of tick_en; takes priority over timer expiry in the same cycle.
- ped_req coinciding with its own GREEN entry: entry clears the latch, walk asserted, new request not retained.
- Duration inputs changed mid-phase have no effect until the next phase entry.
- rst_n assertion mid-phase forces reset values immediately (asynchronously); deassertion synchronised externally.

## Structure
- Shared package traffic_pkg: phase_t enum (ALLRED, GREEN, YELLOW, FLASH, 2-bit), phase encodings reused by status registers.
- One sub-module natural: tl_dir_arbiter (combinational round-robin next-direction pick with demand mask and SKIP_EMPTY).

## Test plan
- Reset, green_len=3, yellow_len=2, allred_len=1, NUM_DIR=2, tick_en every cycle, no demand, SKIP_EMPTY=0 → sequence ALLRED(1), dir1... period 12 ticks per full cycle, dirs alternate 1,0,1.
- SKIP_EMPTY=1, NUM_DIR=4, car_present=4'b1000 only → every green served to dir 3; dirs 1,2 never green.
- ped_req pulse on dir 2 during dir 0 green, WALK_TICKS=4, green_len=6 → dir 2 green next (skipped dir 1 with no demand), walk[2] high 4 ticks, latch cleared.
- green_len=0 → green lasts exactly 1 tick; WALK_TICKS=4 → walk drops with green after 1 tick.
- flash_mode raised mid-GREEN → next clk all red/green off, yellow blink toggles per tick; drop flash_mode → ALLRED, active_dir=0.
- rst_n low mid-YELLOW between clk edges → outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared phase encoding for the traffic light controller.
// The same 2-bit codes appear on the phase output and in status registers.
package traffic_pkg;

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        FLASH  = 2'd3
    } phase_t;

endpackage

// File: rtl/tl_dir_arbiter.sv
// Combinational round-robin pick of the next approach to serve.
// Search starts just after cur and wraps back onto cur itself.
module tl_dir_arbiter #(
    parameter int NUM_DIR    = 2,
    parameter bit SKIP_EMPTY = 1'b1
) (
    input  logic [$clog2(NUM_DIR)-1:0] cur,
    input  logic [NUM_DIR-1:0]         demand,
    output logic [$clog2(NUM_DIR)-1:0] nxt
);

    localparam int DW = $clog2(NUM_DIR);

    logic [DW-1:0] plain;
    logic [DW-1:0] pick;
    logic          found;
    int            idx;

    assign plain = (cur == DW'(NUM_DIR - 1)) ? '0 : cur + 1'b1;

    always_comb begin
        nxt   = plain;
        found = 1'b0;
        idx   = 0;
        pick  = '0;
        if (SKIP_EMPTY) begin
            for (int i = 1; i <= NUM_DIR; i++) begin
                idx  = (int'(cur) + i) % NUM_DIR;
                pick = DW'(idx);
                if (!found && demand[pick]) begin
                    nxt   = pick;
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin traffic light controller with ped latches and flash fallback.
// Lamps are registered from next-state so they move on the same edge as phase.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 2,
    parameter int CNT_W      = 8,
    parameter int WALK_TICKS = 4,
    parameter bit SKIP_EMPTY = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick_en,
    input  logic [CNT_W-1:0]           green_len,
    input  logic [CNT_W-1:0]           yellow_len,
    input  logic [CNT_W-1:0]           allred_len,
    input  logic [NUM_DIR-1:0]         car_present,
    input  logic [NUM_DIR-1:0]         ped_req,
    input  logic                       flash_mode,
    output logic [NUM_DIR-1:0]         red,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         green,
    output logic [NUM_DIR-1:0]         walk,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic [1:0]                 phase
);

    localparam int DW = $clog2(NUM_DIR);
    localparam int WW = $clog2(WALK_TICKS + 1);

    phase_t             ph_q, ph_d;
    logic [DW-1:0]      dir_q, dir_d, nxt_dir;
    logic [CNT_W-1:0]   tmr_q, tmr_d;
    logic [WW-1:0]      wcnt_q, wcnt_d;
    logic               blink_q, blink_d;
    logic [NUM_DIR-1:0] ped_q, ped_d, ped_any;
    logic [NUM_DIR-1:0] red_d, yel_d, grn_d, walk_d, dir_oh;
    logic               expire;

    // Timer holds ticks remaining minus one; zero length behaves as one.
    function automatic logic [CNT_W-1:0] load(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    assign ped_any = ped_q | ped_req;
    assign expire  = tick_en && (tmr_q == '0);

    tl_dir_arbiter #(
        .NUM_DIR    (NUM_DIR),
        .SKIP_EMPTY (SKIP_EMPTY)
    ) u_arb (
        .cur    (dir_q),
        .demand (car_present | ped_any),
        .nxt    (nxt_dir)
    );

    always_comb begin
        ph_d    = ph_q;
        dir_d   = dir_q;
        tmr_d   = tmr_q;
        wcnt_d  = wcnt_q;
        blink_d = blink_q;
        ped_d   = ped_any;
        if (flash_mode) begin
            ph_d    = FLASH;
            wcnt_d  = '0;
            blink_d = (ph_q == FLASH) ? (blink_q ^ tick_en) : 1'b1;
        end else if (tick_en) begin
            if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
            if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
            unique case (ph_q)
                ALLRED: if (expire) begin
                    ph_d   = GREEN;
                    dir_d  = nxt_dir;
                    tmr_d  = load(green_len);
                    wcnt_d = ped_any[nxt_dir] ? WW'(WALK_TICKS) : '0;
                    ped_d[nxt_dir] = 1'b0;
                end
                GREEN: if (expire) begin
                    ph_d   = YELLOW;
                    tmr_d  = load(yellow_len);
                    wcnt_d = '0;
                end
                YELLOW: if (expire) begin
                    ph_d  = ALLRED;
                    tmr_d = load(allred_len);
                end
                FLASH: begin
                    ph_d  = ALLRED;
                    dir_d = '0;
                    tmr_d = load(allred_len);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dir_oh = NUM_DIR'(1) << dir_d;
        red_d  = '1;
        yel_d  = '0;
        grn_d  = '0;
        walk_d = '0;
        unique case (ph_d)
            GREEN: begin
                red_d = ~dir_oh;
                grn_d = dir_oh;
                if (wcnt_d != '0) walk_d = dir_oh;
            end
            YELLOW: begin
                red_d = ~dir_oh;
                yel_d = dir_oh;
            end
            FLASH: begin
                red_d = '0;
                yel_d = {NUM_DIR{blink_d}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q    <= ALLRED;
            dir_q   <= '0;
            tmr_q   <= '0;
            wcnt_q  <= '0;
            blink_q <= 1'b0;
            ped_q   <= '0;
            red     <= '1;
            yellow  <= '0;
            green   <= '0;
            walk    <= '0;
        end else begin
            ph_q    <= ph_d;
            dir_q   <= dir_d;
            tmr_q   <= tmr_d;
            wcnt_q  <= wcnt_d;
            blink_q <= blink_d;
            ped_q   <= ped_d;
            red     <= red_d;
            yellow  <= yel_d;
            green   <= grn_d;
            walk    <= walk_d;
        end
    end

    assign active_dir = dir_q;
    assign phase      = ph_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: tick-level reference model plus directed pins.
// Four approaches, demand skipping on, walk held four ticks.
module tb_traffic_light_ctrl;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int WT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick_en = 1'b0;
    logic          flash_mode = 1'b0;
    logic [CW-1:0] green_len = 8'd3;
    logic [CW-1:0] yellow_len = 8'd2;
    logic [CW-1:0] allred_len = 8'd1;
    logic [N-1:0]  car_present = '0;
    logic [N-1:0]  ped_req = '0;
    logic [N-1:0]  red, yellow, green, walk;
    logic [1:0]    active_dir;
    logic [1:0]    phase;

    int errors = 0;
    int checks = 0;

    traffic_light_ctrl #(
        .NUM_DIR    (N),
        .CNT_W      (CW),
        .WALK_TICKS (WT),
        .SKIP_EMPTY (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_en     (tick_en),
        .green_len   (green_len),
        .yellow_len  (yellow_len),
        .allred_len  (allred_len),
        .car_present (car_present),
        .ped_req     (ped_req),
        .flash_mode  (flash_mode),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .walk        (walk),
        .active_dir  (active_dir),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0..3, ticks left in phase, walk ticks left.
    int m_ph = 0, m_dir = 0, m_left = 1, m_walk = 0, m_blink = 0;
    bit m_ped[N];

    function automatic int max1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int pick(input int cur);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (cur + k) % N;
            if (car_present[c] || m_ped[c]) return c;
        end
        return (cur + 1) % N;
    endfunction

    initial begin : model_p
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ph = 0; m_dir = 0; m_left = 1; m_walk = 0; m_blink = 0;
                for (int d = 0; d < N; d++) m_ped[d] = 1'b0;
            end else begin
                for (int d = 0; d < N; d++) if (ped_req[d]) m_ped[d] = 1'b1;
                if (flash_mode) begin
                    if (m_ph != 3) begin
                        m_ph = 3; m_blink = 1;
                    end else if (tick_en) begin
                        m_blink = 1 - m_blink;
                    end
                end else if (tick_en) begin
                    if (m_ph == 3) begin
                        m_ph = 0; m_dir = 0; m_left = max1(int'(allred_len));
                    end else begin
                        m_left--;
                        if (m_ph == 1 && m_walk > 0) m_walk--;
                        if (m_left == 0) begin
                            if (m_ph == 0) begin
                                m_dir = pick(m_dir);
                                m_ph = 1;
                                m_walk = m_ped[m_dir] ? WT : 0;
                                m_ped[m_dir] = 1'b0;
                                m_left = max1(int'(green_len));
                            end else if (m_ph == 1) begin
                                m_ph = 2; m_left = max1(int'(yellow_len));
                            end else begin
                                m_ph = 0; m_left = max1(int'(allred_len));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : cmp_p
        logic [N-1:0] er, ey, eg, ew;
        forever begin
            @(negedge clk);
            for (int d = 0; d < N; d++) begin
                er[d] = (m_ph == 0) || (m_ph != 3 && d != m_dir);
                ey[d] = (m_ph == 2 && d == m_dir) || (m_ph == 3 && m_blink != 0);
                eg[d] = (m_ph == 1 && d == m_dir);
                ew[d] = eg[d] && m_walk > 0;
            end
            chk("lamps", {red, yellow, green, walk}, {er, ey, eg, ew});
            chk("state", {active_dir, phase}, {2'(m_dir), 2'(m_ph)});
            chk("one_green", 32'($countones(green) <= 1), 1);
        end
    end

    task automatic next_green(output int d, output int c);
        logic [1:0] prev;
        c = 0;
        d = -1;
        while (c < 200) begin
            prev = phase;
            @(negedge clk);
            c++;
            if (phase == 2'd1 && prev != 2'd1) begin
                d = int'(active_dir);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL green_wait: no new green within %0d cycles", c);
    endtask

    task automatic count_green(output int g, output int w);
        g = 0;
        w = 0;
        while (phase == 2'd1 && g < 100) begin
            g++;
            if (walk[active_dir]) w++;
            @(negedge clk);
        end
    endtask

    initial begin : main_p
        int d, c, g, w;
        repeat (2) @(negedge clk);
        chk("rst_phase", phase, 0);
        chk("rst_dir", active_dir, 0);
        chk("rst_lamps", {red, yellow, green, walk}, 16'hF000);

        tick_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_green", {phase, active_dir}, {2'd1, 2'd1});
        next_green(d, c); chk("rr_dir2", d, 2); chk("rr_gap", c, 6);
        next_green(d, c); chk("rr_dir3", d, 3); chk("rr_gap", c, 6);
        next_green(d, c); chk("rr_dir0", d, 0);

        car_present = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            next_green(d, c);
            chk("skip_to3", d, 3);
        end
        car_present = '0;

        green_len = 8'd6;
        next_green(d, c); chk("ped_pre", d, 0);
        @(negedge clk); ped_req = 4'b0100;
        @(negedge clk); ped_req = '0;
        next_green(d, c); chk("ped_dir", d, 2);
        count_green(g, w);
        chk("ped_glen", g, 6);
        chk("ped_walk", w, 4);
        next_green(d, c); chk("ped_cleared", d, 3);

        green_len = 8'd0;
        @(negedge clk); ped_req = 4'b0001;
        @(negedge clk); ped_req = '0;
        next_green(d, c); chk("g0_dir", d, 0);
        count_green(g, w);
        chk("g0_glen", g, 1);
        chk("g0_walk", w, 1);

        green_len = 8'd5;
        next_green(d, c); chk("fl_pre", d, 1);
        @(negedge clk);
        tick_en = 1'b0;
        flash_mode = 1'b1;
        @(negedge clk);
        chk("fl_enter", {phase, red, green, walk, yellow}, {2'd3, 12'h000, 4'hF});
        tick_en = 1'b1;
        @(negedge clk); chk("fl_blink0", yellow, 4'h0);
        @(negedge clk); chk("fl_blink1", yellow, 4'hF);
        flash_mode = 1'b0;
        @(negedge clk);
        chk("fl_exit", {phase, active_dir, red}, {2'd0, 2'd0, 4'hF});

        c = 0;
        while (phase != 2'd2 && c < 50) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #2;
        chk("ar_pre", phase, 2);
        rst_n = 1'b0;
        #1;
        chk("ar_phase", {phase, active_dir}, 0);
        chk("ar_lamps", {red, yellow, green, walk}, 16'hF000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            tick_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) car_present = 4'($urandom);
            ped_req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
            if ($urandom_range(0, 7) == 0) green_len = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) yellow_len = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) allred_len = 8'($urandom_range(0, 2));
            if ($urandom_range(0, 149) == 0) flash_mode = ~flash_mode;
        end
        flash_mode = 1'b0;
        ped_req = '0;
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
